// File: rtl/wifi_pkg.sv
// Shared definitions for the WiFi sender scheduler:
// FSM encodings, error codes and default timeouts.
package wifi_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_RISE  = 3'd2;
  localparam logic [2:0] S_FALL  = 3'd3;
  localparam logic [2:0] S_ACK   = 3'd4;

  localparam logic [1:0] E_NONE  = 2'b00;
  localparam logic [1:0] E_START = 2'b01;
  localparam logic [1:0] E_DONE  = 2'b10;

  localparam int START_WAIT_DEF = 16;
  localparam int DONE_WAIT_DEF  = 1048575;
  localparam int CNT_W_DEF      = 20;

endpackage

// File: rtl/wifi_tx_sched_if.sv
// Requester, sender and status signals of the scheduler.
// slave = scheduler view, master = environment view.
interface wifi_tx_sched_if;

  logic       req0;
  logic [7:0] cmd0;
  logic [7:0] dat0;
  logic       ack0;
  logic       req1;
  logic [7:0] cmd1;
  logic [7:0] dat1;
  logic       ack1;
  logic [7:0] tx_comando;
  logic [7:0] tx_dato;
  logic       tx_start;
  logic       tx_bussy;
  logic       sched_busy;
  logic       gnt;
  logic       err;
  logic [1:0] err_code;
  logic       err_clr;

  modport slave (
    input  req0, cmd0, dat0,
    input  req1, cmd1, dat1,
    input  tx_bussy, err_clr,
    output ack0, ack1,
    output tx_comando, tx_dato, tx_start,
    output sched_busy, gnt, err, err_code
  );

  modport master (
    output req0, cmd0, dat0,
    output req1, cmd1, dat1,
    output tx_bussy, err_clr,
    input  ack0, ack1,
    input  tx_comando, tx_dato, tx_start,
    input  sched_busy, gnt, err, err_code
  );

endinterface

// File: rtl/wifi_rr_arb2.sv
// Two-way combinational round-robin pick.
// On a tie the requester that was not served last wins.
module wifi_rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic valid,
  output logic pick
);

  assign valid = req0 | req1;

  always_comb begin
    pick = 1'b0;
    unique case (1'b1)
      (req0 && req1):  pick = ~last;
      (req1 && !req0): pick = 1'b1;
      default:         pick = 1'b0;
    endcase
  end

endmodule

// File: rtl/wifi_tx_sched.sv
// Shares one WiFi UART sender between two requesters:
// round-robin grant, start pulse, busy tracking, ack.
module wifi_tx_sched
  import wifi_pkg::*;
#(
  parameter int START_WAIT = START_WAIT_DEF,
  parameter int DONE_WAIT  = DONE_WAIT_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input logic            clk,
  input logic            rst,
  wifi_tx_sched_if.slave bus
);

  localparam logic [CNT_W-1:0] START_LIM =
    CNT_W'(START_WAIT - 1);
  localparam logic [CNT_W-1:0] DONE_LIM =
    CNT_W'(DONE_WAIT - 1);

  logic [2:0]       state;
  logic             last;
  logic [CNT_W-1:0] cnt;
  logic             valid;
  logic             pick;

  wifi_rr_arb2 u_arb (
    .req0  (bus.req0),
    .req1  (bus.req1),
    .last  (last),
    .valid (valid),
    .pick  (pick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      last           <= 1'b1;
      cnt            <= '0;
      bus.tx_comando <= '0;
      bus.tx_dato    <= '0;
      bus.tx_start   <= 1'b0;
      bus.ack0       <= 1'b0;
      bus.ack1       <= 1'b0;
      bus.sched_busy <= 1'b0;
      bus.gnt        <= 1'b0;
      bus.err        <= 1'b0;
      bus.err_code   <= E_NONE;
    end else begin
      bus.tx_start <= 1'b0;
      bus.ack0     <= 1'b0;
      bus.ack1     <= 1'b0;
      // a timeout below overrides a same-cycle clear
      if (bus.err_clr) begin
        bus.err      <= 1'b0;
        bus.err_code <= E_NONE;
      end
      unique case (state)
        S_IDLE: begin
          if (valid) begin
            state          <= S_START;
            bus.tx_start   <= 1'b1;
            bus.sched_busy <= 1'b1;
            bus.gnt        <= pick;
            bus.tx_comando <= pick ? bus.cmd1 : bus.cmd0;
            bus.tx_dato    <= pick ? bus.dat1 : bus.dat0;
          end
        end
        S_START: begin
          cnt   <= '0;
          state <= S_RISE;
        end
        S_RISE: begin
          if (bus.tx_bussy) begin
            cnt   <= '0;
            state <= S_FALL;
          end else if (cnt == START_LIM) begin
            bus.err      <= 1'b1;
            bus.err_code <= E_START;
            bus.ack0     <= ~bus.gnt;
            bus.ack1     <= bus.gnt;
            state        <= S_ACK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_FALL: begin
          if (!bus.tx_bussy) begin
            bus.ack0 <= ~bus.gnt;
            bus.ack1 <= bus.gnt;
            state    <= S_ACK;
          end else if (cnt == DONE_LIM) begin
            bus.err      <= 1'b1;
            bus.err_code <= E_DONE;
            bus.ack0     <= ~bus.gnt;
            bus.ack1     <= bus.gnt;
            state        <= S_ACK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_ACK: begin
          last           <= bus.gnt;
          bus.sched_busy <= 1'b0;
          state          <= S_IDLE;
        end
        default: begin
          state          <= S_IDLE;
          bus.sched_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wifi_tx_sched.sv
// Scoreboard bench for wifi_tx_sched with a
// behavioural sender model (normal / never / hold).
module tb_wifi_tx_sched;

  typedef struct {
    int gnt;
    int cmd;
    int dat;
  } st_t;

  typedef struct {
    int idx;
    int err;
    int code;
    int lat;
  } ak_t;

  localparam int M_NORMAL = 0;
  localparam int M_NEVER  = 1;
  localparam int M_HOLD   = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  wifi_tx_sched_if bus();

  wifi_tx_sched #(
    .START_WAIT (16),
    .DONE_WAIT  (50),
    .CNT_W      (20)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  int  t_start = 0;
  int  mode = M_NORMAL;
  int  blen = 4;
  int  left = 0;
  bit  start_d = 1'b0;
  st_t start_q[$];
  ak_t ack_q[$];

  task automatic chk(string n, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               n, act, exp);
    end
  endtask

  // sender model: bussy rises the cycle after start
  initial begin
    bus.tx_bussy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        bus.tx_bussy = 1'b0;
        left = 0;
        start_d = 1'b0;
      end else begin
        if (left > 0) left--;
        if (left == 0 && mode != M_HOLD)
          bus.tx_bussy = 1'b0;
        if (start_d) begin
          bus.tx_bussy = 1'b1;
          left = blen;
        end
        start_d = bus.tx_start && mode != M_NEVER;
      end
    end
  end

  // monitor: pops expectations on start and ack
  always @(negedge clk) begin
    st_t s;
    ak_t a;
    cyc++;
    if (rst) begin
      if (bus.tx_start) begin
        t_start = cyc;
        if (start_q.size() == 0) begin
          chk("unexpected_start", 1, 0);
        end else begin
          s = start_q.pop_front();
          chk("start_gnt", int'(bus.gnt), s.gnt);
          chk("tx_comando", int'(bus.tx_comando), s.cmd);
          chk("tx_dato", int'(bus.tx_dato), s.dat);
        end
      end
      if (bus.ack0 || bus.ack1) begin
        if (ack_q.size() == 0) begin
          chk("unexpected_ack", 1, 0);
        end else begin
          a = ack_q.pop_front();
          chk("ack_both", int'(bus.ack0 & bus.ack1), 0);
          chk("ack_idx", int'(bus.ack1), a.idx);
          chk("ack_gnt", int'(bus.gnt), a.idx);
          chk("ack_err", int'(bus.err), a.err);
          chk("ack_code", int'(bus.err_code), a.code);
          chk("ack_lat", cyc - t_start, a.lat);
          chk("ack_busy", int'(bus.sched_busy), 1);
        end
      end
    end
  end

  task automatic chk_zero(string n);
    chk({n, "_data"},
        int'({bus.tx_comando, bus.tx_dato}), 0);
    chk({n, "_ctl"},
        int'({bus.tx_start, bus.ack0, bus.ack1,
              bus.sched_busy, bus.gnt}), 0);
    chk({n, "_err"},
        int'({bus.err, bus.err_code}), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.err_clr = 1'b0;
    #1;
    chk_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_start(int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.tx_start) return;
    end
    chk("start_timeout", 1, 0);
  endtask

  task automatic wait_ack(int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.ack0 || bus.ack1) return;
    end
    chk("ack_timeout", 1, 0);
  endtask

  initial begin #300000;
    $display("FAIL watchdog expired");
    $display("[TB] %0d tests run, %0d failed",
             tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.cmd0 = 8'h00;
    bus.dat0 = 8'h00;
    bus.cmd1 = 8'h00;
    bus.dat1 = 8'h00;
    bus.err_clr = 1'b0;

    // single request, sender busy 20 cycles
    do_reset();
    mode = M_NORMAL;
    blen = 20;
    start_q.push_back('{0, 'h41, 'h07});
    ack_q.push_back('{0, 0, 0, 22});
    bus.cmd0 = 8'h41;
    bus.dat0 = 8'h07;
    bus.req0 = 1'b1;
    @(negedge clk);
    chk("req_to_start", int'(bus.tx_start), 1);
    wait_ack(100);
    bus.req0 = 1'b0;
    repeat (3) @(negedge clk);

    // both requesting from reset: 0, 1, 0
    do_reset();
    blen = 3;
    bus.cmd0 = 8'hA0;
    bus.dat0 = 8'h01;
    bus.cmd1 = 8'hB1;
    bus.dat1 = 8'h02;
    start_q.push_back('{0, 'hA0, 'h01});
    ack_q.push_back('{0, 0, 0, 5});
    start_q.push_back('{1, 'hB1, 'h02});
    ack_q.push_back('{1, 0, 0, 5});
    start_q.push_back('{0, 'hA0, 'h01});
    ack_q.push_back('{0, 0, 0, 5});
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    wait_ack(50);
    wait_ack(50);
    wait_start(50);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    wait_ack(50);
    repeat (3) @(negedge clk);

    // start timeout, then clear
    mode = M_NEVER;
    bus.cmd1 = 8'hC3;
    bus.dat1 = 8'h33;
    start_q.push_back('{1, 'hC3, 'h33});
    ack_q.push_back('{1, 1, 1, 17});
    bus.req1 = 1'b1;
    wait_ack(100);
    bus.req1 = 1'b0;
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    chk("clr_err", int'(bus.err), 0);
    chk("clr_code", int'(bus.err_code), 0);
    repeat (2) @(negedge clk);

    // done timeout, then a normal transfer
    mode = M_HOLD;
    bus.cmd0 = 8'h44;
    bus.dat0 = 8'h55;
    start_q.push_back('{0, 'h44, 'h55});
    ack_q.push_back('{0, 1, 2, 52});
    bus.req0 = 1'b1;
    wait_ack(200);
    bus.req0 = 1'b0;
    mode = M_NORMAL;
    blen = 4;
    repeat (3) @(negedge clk);
    chk("sticky_err", int'(bus.err), 1);
    bus.cmd1 = 8'h5A;
    bus.dat1 = 8'hA5;
    start_q.push_back('{1, 'h5A, 'hA5});
    ack_q.push_back('{1, 1, 2, 6});
    bus.req1 = 1'b1;
    wait_ack(100);
    bus.req1 = 1'b0;
    repeat (2) @(negedge clk);

    // clear collides with a new start timeout
    mode = M_NEVER;
    bus.cmd0 = 8'h11;
    bus.dat0 = 8'h22;
    start_q.push_back('{0, 'h11, 'h22});
    ack_q.push_back('{0, 1, 1, 17});
    bus.req0 = 1'b1;
    wait_start(20);
    repeat (16) @(posedge clk);
    #1;
    bus.err_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.err_clr = 1'b0;
    wait_ack(20);
    bus.req0 = 1'b0;
    repeat (2) @(negedge clk);
    chk("collide_err", int'(bus.err), 1);
    chk("collide_code", int'(bus.err_code), 1);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;

    // reset in WAIT_FALL, then requester 1
    mode = M_HOLD;
    bus.cmd0 = 8'h99;
    bus.dat0 = 8'h88;
    start_q.push_back('{0, 'h99, 'h88});
    bus.req0 = 1'b1;
    wait_start(20);
    repeat (5) @(negedge clk);
    do_reset();
    mode = M_NORMAL;
    blen = 4;
    repeat (2) @(negedge clk);
    chk("no_ack_q", ack_q.size(), 0);
    bus.cmd1 = 8'h66;
    bus.dat1 = 8'h77;
    start_q.push_back('{1, 'h66, 'h77});
    ack_q.push_back('{1, 0, 0, 6});
    bus.req1 = 1'b1;
    wait_ack(100);
    bus.req1 = 1'b0;
    repeat (5) @(negedge clk);

    chk("start_q_empty", start_q.size(), 0);
    chk("ack_q_empty", ack_q.size(), 0);
    chk("idle_busy", int'(bus.sched_busy), 0);
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
